// File: rtl/rns11_tc_add_sched_if.sv
// rtl/rns11_tc_add_sched_if.sv - request/result bundle for the shared mod-11 thermometer-code adder
interface rns11_tc_add_sched_if;
  logic       in0_valid;
  logic       in0_ready;
  logic [3:0] in0_a;
  logic [3:0] in0_b;
  logic       in1_valid;
  logic       in1_ready;
  logic [3:0] in1_a;
  logic [3:0] in1_b;
  logic       out_valid;
  logic       out_ready;
  logic       out_id;
  logic [9:0] out_tc;
  logic [3:0] out_bin;
  logic       out_err;
  logic       busy;

  modport master (
    output in0_valid, in0_a, in0_b, in1_valid, in1_a, in1_b, out_ready,
    input  in0_ready, in1_ready, out_valid, out_id, out_tc, out_bin, out_err, busy
  );

  modport slave (
    input  in0_valid, in0_a, in0_b, in1_valid, in1_a, in1_b, out_ready,
    output in0_ready, in1_ready, out_valid, out_id, out_tc, out_bin, out_err, busy
  );
endinterface

// File: rtl/rns11_tc_add_sched.sv
// rtl/rns11_tc_add_sched.sv - two-requester mod-11 adder stepping a thermometer code b times
// Optional operand range check enabled by defining RNS11_RANGE_CHK_EN.
module rns11_tc_add_sched (
  input  logic                 clk,
  input  logic                 rst,
  rns11_tc_add_sched_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_q;
  logic       last_q;
  logic       id_q;
  logic [9:0] acc_q;
  logic [3:0] cnt_q;
  logic       out_valid_q;
  logic       out_id_q;
  logic [9:0] out_tc_q;
  logic [3:0] out_bin_q;
  logic       grant0;
  logic       grant1;
  logic [3:0] sel_a;
  logic [3:0] sel_b;

  function automatic logic [9:0] tc_of(input logic [3:0] v);
    logic [9:0] t;
    t = '0;
    if (v <= 4'd10)
      for (int i = 0; i < 10; i++) t[i] = (4'(i) < v);
    return t;
  endfunction

  function automatic logic [9:0] tc_inc(input logic [9:0] t);
    return (t == 10'h3FF) ? 10'h000 : {t[8:0], 1'b1};
  endfunction

  function automatic logic [3:0] popcnt(input logic [9:0] t);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 10; i++) n = n + {3'b000, t[i]};
    return n;
  endfunction

  // The requester not served last time wins a contention.
  always_comb begin
    grant0 = !rst && (state_q == IDLE) && bus.in0_valid && (!bus.in1_valid || last_q);
    grant1 = !rst && (state_q == IDLE) && bus.in1_valid && (!bus.in0_valid || !last_q);
  end

  assign sel_a = grant1 ? bus.in1_a : bus.in0_a;
  assign sel_b = grant1 ? bus.in1_b : bus.in0_b;

`ifdef RNS11_RANGE_CHK_EN
  logic err_q;
  logic out_err_q;
  logic range_bad;
  assign range_bad = (sel_a > 4'd10) || (sel_b > 4'd10);
  assign bus.out_err = out_err_q;
`else
  assign bus.out_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_tc_q    <= '0;
      out_bin_q   <= '0;
`ifdef RNS11_RANGE_CHK_EN
      err_q       <= 1'b0;
      out_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            acc_q   <= tc_of(sel_a);
            cnt_q   <= (sel_b > 4'd10) ? 4'd0 : sel_b;
            id_q    <= grant1;
            last_q  <= grant1;
            state_q <= RUN;
`ifdef RNS11_RANGE_CHK_EN
            err_q   <= range_bad;
            // A bad operand skips the increments and reports zero one cycle later.
            if (range_bad) begin
              acc_q <= '0;
              cnt_q <= '0;
            end
`endif
          end
        end
        RUN: begin
          if (cnt_q == 4'd0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_tc_q    <= acc_q;
            out_bin_q   <= popcnt(acc_q);
            out_id_q    <= id_q;
`ifdef RNS11_RANGE_CHK_EN
            out_err_q   <= err_q;
`endif
          end else begin
            acc_q <= tc_inc(acc_q);
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_id_q    <= 1'b0;
            out_tc_q    <= '0;
            out_bin_q   <= '0;
`ifdef RNS11_RANGE_CHK_EN
            out_err_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in0_ready = grant0;
  assign bus.in1_ready = grant1;
  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_tc    = out_tc_q;
  assign bus.out_bin   = out_bin_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_rns11_tc_add_sched.sv
// tb/tb_rns11_tc_add_sched.sv - directed-vector bench for the shared mod-11 adder
module tb_rns11_tc_add_sched;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  rns11_tc_add_sched_if bus ();

  rns11_tc_add_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [3:0] a, input logic [3:0] b);
    if (p == 0) begin
      bus.in0_valid = v; bus.in0_a = a; bus.in0_b = b;
    end else begin
      bus.in1_valid = v; bus.in1_a = a; bus.in1_b = b;
    end
  endtask

  task automatic wait_accept(input string tag, input int p);
    logic got;
    logic both;
    logic other;
    got   = 1'b0;
    both  = 1'b0;
    other = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got   = (p == 0) ? bus.in0_ready : bus.in1_ready;
      both  = bus.in0_valid && bus.in1_valid;
      other = (p == 0) ? bus.in1_ready : bus.in0_ready;
    end
    check({tag, "_accept"}, got, 1);
    if (both) check({tag, "_loser_ready"}, other, 0);
    @(posedge clk);
    #1;
    if (p == 0) bus.in0_valid = 1'b0;
    else        bus.in1_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int elat, input logic [3:0] eb,
                             input logic [9:0] et, input logic eid, input logic eerr);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_bin"}, bus.out_bin, eb);
    check({tag, "_tc"},  bus.out_tc, et);
    check({tag, "_id"},  bus.out_id, eid);
    check({tag, "_err"}, bus.out_err, eerr);
    if (bus.out_ready) begin
      @(posedge clk);
      #1;
      check({tag, "_idle"}, {bus.busy, bus.out_valid}, 0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    set_req(0, 1'b1, 4'd2, 4'd2);
    set_req(1, 1'b1, 4'd5, 4'd6);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {bus.in0_ready, bus.in1_ready}, 0);
    check("rst_out", {bus.out_valid, bus.out_id, bus.out_err, bus.busy}, 0);
    check("rst_tc_bin", {bus.out_tc, bus.out_bin}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Contention straight out of reset: in0 first, then in1, then in0 again.
    wait_accept("arb0", 0);
    wait_result("arb0", 3, 4'd4, 10'b0000001111, 1'b0, 1'b0);
    wait_accept("arb1", 1);
    wait_result("arb1", 7, 4'd0, 10'b0000000000, 1'b1, 1'b0);
    set_req(0, 1'b1, 4'd2, 4'd2);
    set_req(1, 1'b1, 4'd5, 4'd6);
    wait_accept("arb2", 0);
    wait_result("arb2", 3, 4'd4, 10'b0000001111, 1'b0, 1'b0);
    wait_accept("arb3", 1);
    wait_result("arb3", 7, 4'd0, 10'b0000000000, 1'b1, 1'b0);

    set_req(0, 1'b1, 4'd3, 4'd4);
    wait_accept("add34", 0);
    wait_result("add34", 5, 4'd7, 10'b0001111111, 1'b0, 1'b0);
    set_req(1, 1'b1, 4'd9, 4'd5);
    wait_accept("add95", 1);
    wait_result("add95", 6, 4'd3, 10'b0000000111, 1'b1, 1'b0);
    set_req(0, 1'b1, 4'd10, 4'd1);
    wait_accept("add101", 0);
    wait_result("add101", 2, 4'd0, 10'b0000000000, 1'b0, 1'b0);
    set_req(0, 1'b1, 4'd10, 4'd0);
    wait_accept("add100", 0);
    wait_result("add100", 1, 4'd10, 10'b1111111111, 1'b0, 1'b0);
    set_req(1, 1'b1, 4'd0, 4'd0);
    wait_accept("add00", 1);
    wait_result("add00", 1, 4'd0, 10'b0000000000, 1'b1, 1'b0);

    set_req(0, 1'b1, 4'd12, 4'd3);
    wait_accept("range", 0);
`ifdef RNS11_RANGE_CHK_EN
    wait_result("range", 1, 4'd0, 10'b0000000000, 1'b0, 1'b1);
`else
    wait_result("range", 4, 4'd3, 10'b0000000111, 1'b0, 1'b0);
`endif

    // Backpressure: result must hold while out_ready is low, no grants.
    bus.out_ready = 1'b0;
    set_req(1, 1'b1, 4'd1, 4'd1);
    wait_accept("bp", 1);
    wait_result("bp", 2, 4'd2, 10'b0000000011, 1'b1, 1'b0);
    set_req(0, 1'b1, 4'd4, 4'd4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid_busy", {bus.out_valid, bus.busy}, 2'b11);
      check("bp_hold_data", {bus.out_id, bus.out_bin, bus.out_tc}, {1'b1, 4'd2, 10'b0000000011});
      check("bp_hold_ready", {bus.in0_ready, bus.in1_ready}, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {bus.out_valid, bus.busy}, 0);
    wait_accept("bp_next", 0);
    wait_result("bp_next", 5, 4'd8, 10'b0011111111, 1'b0, 1'b0);

    // Reset while running discards the request and re-arms the pointer.
    set_req(0, 1'b1, 4'd1, 4'd8);
    wait_accept("rrun", 0);
    repeat (3) @(posedge clk);
    #1;
    check("rrun_busy", bus.busy, 1);
    rst = 1'b1;
    set_req(0, 1'b1, 4'd6, 4'd0);
    set_req(1, 1'b1, 4'd7, 4'd0);
    #1;
    check("rrun_out", {bus.out_valid, bus.busy, bus.out_id, bus.out_err}, 0);
    check("rrun_tc_bin", {bus.out_tc, bus.out_bin}, 0);
    check("rrun_ready", {bus.in0_ready, bus.in1_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_accept("rrun0", 0);
    wait_result("rrun0", 1, 4'd6, 10'b0000111111, 1'b0, 1'b0);
    wait_accept("rrun1", 1);
    wait_result("rrun1", 1, 4'd7, 10'b0001111111, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rns11_tc_add_sched.md
# rns11_tc_add_sched

Shared sequential modulo-11 residue adder for the mod-11 channel of the RNS modulo adder. It arbitrates between two requesters and converts the winning operand `a` from binary to 10-bit thermometer code. The sum is formed by incrementing that thermometer value `b` times, modulo 11. The result is returned in both thermometer and binary form with a valid/ready handshake.

## Interface
- Parameters: none. Modulus is fixed at 11 and thermometer width at 10.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in0_valid` input 1: requester 0 operand pair valid.
- `in0_ready` output 1: requester 0 pair accepted this cycle.
- `in0_a` input 4: requester 0 residue a, binary, 0..10.
- `in0_b` input 4: requester 0 residue b, binary, 0..10.
- `in1_valid`, `in1_ready`, `in1_a`, `in1_b`: same as the requester 0 ports, for requester 1.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.
- `out_id` output 1: requester index of the result.
- `out_tc` output 10: (a+b) mod 11, thermometer code, value v = v low-order ones.
- `out_bin` output 4: (a+b) mod 11, binary.
- `out_err` output 1: operand range error. Constant 0 unless the macro below is defined.
- `busy` output 1: state is not IDLE.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `inX_ready` is combinational: IDLE & `inX_valid` & (other requester not valid | round-robin pointer favours X).
  - Pointer `last` holds the index last accepted. When both requesters are valid, the one ≠ `last` wins.
- **Accept edge** (a valid & ready pair)
  - `acc` <= TC(a), where TC(v) = v low ones. TC maps any out-of-range code (11..15) to 0.
  - `cnt` <= b. Codes 11..15 become 0.
  - `id` <= X, `last` <= X, state <= RUN.
- **RUN**
  - If `cnt`==0: state <= DONE.
  - Else: `acc` <= inc(acc), `cnt` <= `cnt`−1.
  - inc(t) = 0 when t = 10'b1111111111; otherwise {t[8:0],1'b1}.
- **DONE**
  - `out_valid`=1. `out_tc`=`acc`. `out_bin`=popcount(`acc`). `out_id`=`id`.
  - On `out_ready`, state <= IDLE.
  - All result outputs stay stable while `out_ready`=0.
- Inputs are sampled only at the accept edge. Requesters hold valid/data until ready.
- No new request is accepted in RUN or DONE. Both readies are 0.

## Timing
- Reset values:
  - State IDLE, `last`=1, so requester 0 wins the first contention.
  - `acc`=0, `cnt`=0, `id`=0.
  - `out_valid`=0, `out_tc`=0, `out_bin`=0, `out_id`=0, `out_err`=0, `busy`=0.
  - `in0_ready`=0 and `in1_ready`=0 while `rst` is high.
- Latency: `out_valid` rises b+1 cycles after the accept edge. b=0 gives 1 cycle; b=10 gives 11 cycles.
- Result accepted with `out_ready`=1 in DONE: IDLE on the next edge. The earliest next accept is the edge after that, so there is one bubble.
- Throughput: one request per b+3 cycles minimum.
- Simultaneous valids: only one grant per cycle. The loser's ready stays 0, and it wins the next contention.
- Reset mid-operation: the in-flight request is discarded with no output. All state returns to reset values immediately.

## Configuration
- `RNS11_RANGE_CHK_EN`
  - Defined:
    - On accept, if a>10 or b>10, go directly to DONE with `acc`=0 and `out_err`=1. Latency is 1.
    - `out_err` clears when the result is accepted.
    - In-range operands behave exactly as in Operation, with `out_err`=0.
  - Undefined:
    - Out-of-range a or b is treated as 0, as described in Operation.
    - `out_err` is tied to 0 and no checking logic is present.

## Test plan
- Basic add: in0 a=3, b=4, `out_ready`=1 → `out_valid` rises 5 cycles after accept, `out_bin`=7, `out_tc`=0001111111, `out_id`=0.
- Wrap-around: in1 a=9, b=5 → `out_bin`=3, `out_tc`=0000000111, latency 6 cycles. Also a=10, b=1 → `out_tc`=0, `out_bin`=0.
- Zero increment: a=10, b=0 → latency 1, `out_tc`=1111111111, `out_bin`=10. Also a=0, b=0 → 0.
- Arbitration: right after reset, in0 (2,2) and in1 (5,6) are both held valid.
  - in0 is served first: `out_bin`=4, id 0.
  - Then in1: `out_bin`=0, id 1.
  - A repeated simultaneous pair is served in0 first again.
- Backpressure and reset: hold `out_ready`=0 for 3 cycles in DONE → outputs stable, both readies 0, `busy`=1. Separately, assert `rst` in RUN with b=8 → no `out_valid`, all outputs 0, `last`=1.
- Range check with `RNS11_RANGE_CHK_EN`: a=12, b=3 → `out_err`=1, `out_bin`=0, latency 1. Without the macro, the same stimulus → `out_bin`=3, `out_err`=0, latency 4.
